// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants, stall patterns and state encoding for the pipeline stall controller.
package pipeline_stall_ctrl_pkg;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  localparam int unsigned CNT_W  = 6;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

  // bit 0 = PC ... bit 5 = WB; freezing a stage always freezes everything upstream
  localparam logic [5:0] STALL_NONE = {6{STALL_DISABLE}};
  localparam logic [5:0] STALL_ID   = {{3{STALL_DISABLE}}, {3{STALL_ENABLE}}};
  localparam logic [5:0] STALL_EX   = {{2{STALL_DISABLE}}, {4{STALL_ENABLE}}};
  localparam logic [5:0] STALL_MEM  = {STALL_DISABLE, {5{STALL_ENABLE}}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_DIV_HOLD = 2'd2,
    ST_FLUSH    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall bundle between the pipeline stages and the stall controller.
interface pipeline_stall_ctrl_if;
  logic        id_stall_req;
  logic        ex_div_start;
  logic        mem_stall_req;
  logic        mem_exc_req;
  logic [31:0] mem_epc;
  logic [5:0]  stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic        div_busy;
  logic        div_done;

  // pipeline side: raises requests, consumes stall/flush/redirect
  modport master (
    output id_stall_req, ex_div_start, mem_stall_req, mem_exc_req, mem_epc,
    input  stall, flush, redirect_valid, redirect_pc, epc, div_busy, div_done
  );

  // controller side
  modport slave (
    input  id_stall_req, ex_div_start, mem_stall_req, mem_exc_req, mem_epc,
    output stall, flush, redirect_valid, redirect_pc, epc, div_busy, div_done
  );
endinterface

// File: rtl/pipeline_stall_ctrl_div_latency_counter.sv
// Loadable down-counter with zero flag; saturates at zero. Shared by multi-cycle EX units.
module div_latency_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (load_i)                 cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RESET_ENABLE) cnt_q <= '0;
    else                       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard/stall controller: merges ID/EX/MEM stall requests, runs divide latency and exception flush.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  pipeline_stall_ctrl_if.slave bus
);

  ctrl_state_e state_q, state_d;
  logic        flush_q, redirect_valid_q;
  logic [31:0] redirect_pc_q, epc_q;

  logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  logic       in_rst;
  logic [5:0] stall;
  logic       div_done, div_busy;

  assign in_rst = (reset_i == RESET_ENABLE);

  div_latency_counter #(.W(CNT_W)) u_div_cnt (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(DIV_CYCLES - 1)),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    div_done = 1'b0;
    div_busy = (state_q == ST_DIV_BUSY) || (state_q == ST_DIV_HOLD);

    unique case (state_q)
      ST_RUN: begin
        if (bus.mem_exc_req)       state_d = ST_FLUSH;
        else if (bus.ex_div_start) begin
          state_d  = ST_DIV_BUSY;
          cnt_load = 1'b1;
        end
      end
      ST_DIV_BUSY: begin
        cnt_dec = 1'b1;
        if (bus.mem_exc_req) begin
          state_d = ST_FLUSH;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          if (!bus.mem_stall_req) begin
            div_done = 1'b1;
            state_d  = ST_RUN;
          end else begin
            state_d  = ST_DIV_HOLD;
          end
        end
      end
      ST_DIV_HOLD: begin
        if (bus.mem_exc_req) begin
          state_d = ST_FLUSH;
          cnt_clr = 1'b1;
        end else if (!bus.mem_stall_req) begin
          div_done = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // only the highest-priority request reaches the stage registers
    stall = STALL_NONE;
    if (state_q == ST_FLUSH)     stall = STALL_NONE;
    else if (bus.mem_stall_req)  stall = STALL_MEM;
    else if ((state_q == ST_DIV_BUSY && !cnt_zero) ||
             (state_q == ST_RUN && bus.ex_div_start))
                                 stall = STALL_EX;
    else if (bus.id_stall_req)   stall = STALL_ID;

    if (in_rst) begin
      stall    = STALL_NONE;
      div_done = 1'b0;
      div_busy = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (in_rst) begin
      state_q          <= ST_RUN;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      epc_q            <= '0;
    end else begin
      state_q          <= state_d;
      flush_q          <= (state_d == ST_FLUSH);
      redirect_valid_q <= (state_d == ST_FLUSH);
      redirect_pc_q    <= (state_d == ST_FLUSH) ? EXC_VECTOR : '0;
      if (state_q != ST_FLUSH && state_d == ST_FLUSH) epc_q <= bus.mem_epc;
    end
  end

  assign bus.stall          = stall;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.epc            = epc_q;
  assign bus.div_busy       = div_busy;
  assign bus.div_done       = div_done;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized + directed bench for pipeline_stall_ctrl against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int          D   = 4;
  localparam logic [31:0] EXC = 32'h0000_0020;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeline_stall_ctrl_if bus_if ();

  pipeline_stall_ctrl #(.DIV_CYCLES(D), .EXC_VECTOR(EXC)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycles left until div_done (0 = no divide), waiting-for-MEM flag, flush cycle flag
  int          m_rem   = 0;
  bit          m_hold  = 1'b0;
  bit          m_flush = 1'b0;
  logic [31:0] m_epc   = '0;

  function automatic logic [5:0] exp_stall();
    bit busy;
    busy = (m_rem > 0) || m_hold;
    if (reset || m_flush)                          return 6'b000000;
    if (bus_if.mem_stall_req)                      return 6'b011111;
    if (m_rem > 1 || (!busy && bus_if.ex_div_start)) return 6'b001111;
    if (bus_if.id_stall_req)                       return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic exp_done();
    if (reset || m_flush || bus_if.mem_exc_req || bus_if.mem_stall_req) return 1'b0;
    return (m_rem == 1) || m_hold;
  endfunction

  function automatic logic exp_busy();
    if (reset) return 1'b0;
    return (m_rem > 0) || m_hold;
  endfunction

  always @(posedge clock) begin
    bit busy;
    busy = (m_rem > 0) || m_hold;
    if (reset) begin
      m_rem = 0; m_hold = 0; m_flush = 0; m_epc = '0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (bus_if.mem_exc_req) begin
      m_flush = 1; m_epc = bus_if.mem_epc; m_rem = 0; m_hold = 0;
    end else if (!busy && bus_if.ex_div_start) begin
      m_rem = D;
    end else if (m_rem == 1) begin
      m_rem = 0; m_hold = bus_if.mem_stall_req;
    end else if (m_rem > 1) begin
      m_rem = m_rem - 1;
    end else if (m_hold && !bus_if.mem_stall_req) begin
      m_hold = 0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // continuous check of every output against the model
  always @(negedge clock) begin
    cmp("m_stall",    32'(bus_if.stall),          32'(exp_stall()));
    cmp("m_done",     32'(bus_if.div_done),       32'(exp_done()));
    cmp("m_busy",     32'(bus_if.div_busy),       32'(exp_busy()));
    cmp("m_flush",    32'(bus_if.flush),          32'(m_flush));
    cmp("m_rvalid",   32'(bus_if.redirect_valid), 32'(m_flush));
    cmp("m_rpc",      bus_if.redirect_pc,         m_flush ? EXC : 32'h0);
    cmp("m_epc",      bus_if.epc,                 m_epc);
    if (bus_if.stall[1] && !bus_if.stall[2]) cmp("m_bubble_combo", 32'h1, 32'h0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit id, input bit st, input bit ms, input bit ex, input logic [31:0] pc);
    bus_if.id_stall_req  = id;
    bus_if.ex_div_start  = st;
    bus_if.mem_stall_req = ms;
    bus_if.mem_exc_req   = ex;
    bus_if.mem_epc       = pc;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, '0);
    tick(); tick();
    cmp("rst_stall", 32'(bus_if.stall), 32'h0);
    cmp("rst_flush", 32'(bus_if.flush), 32'h0);
    cmp("rst_rpc",   bus_if.redirect_pc, 32'h0);
    cmp("rst_epc",   bus_if.epc, 32'h0);
    reset = 1'b0;
    tick();

    // load-use only
    drive(1, 0, 0, 0, '0);
    cmp("id_stall", 32'(bus_if.stall), 32'h07);
    cmp("id_flush", 32'(bus_if.flush), 32'h0);
    tick(); drive(0, 0, 0, 0, '0);
    cmp("id_after", 32'(bus_if.stall), 32'h0);
    tick();

    // plain divide: 4 stalled cycles, done on the 4th cycle after start
    drive(0, 1, 0, 0, '0);
    cmp("div_start_stall", 32'(bus_if.stall), 32'h0F);
    for (int k = 0; k < D - 1; k++) begin
      tick(); drive(0, 0, 0, 0, '0);
      cmp("div_run_stall", 32'(bus_if.stall), 32'h0F);
      cmp("div_run_busy",  32'(bus_if.div_busy), 32'h1);
      cmp("div_run_done",  32'(bus_if.div_done), 32'h0);
    end
    tick();
    cmp("div_done",       32'(bus_if.div_done), 32'h1);
    cmp("div_done_stall", 32'(bus_if.stall), 32'h0);
    cmp("div_done_busy",  32'(bus_if.div_busy), 32'h1);
    tick();
    cmp("div_idle_busy",  32'(bus_if.div_busy), 32'h0);

    // MEM stall spanning the end of the divide -> hold, done when MEM releases
    drive(0, 1, 0, 0, '0);
    for (int k = 0; k < 5; k++) begin
      tick(); drive(0, 0, 1, 0, '0);
      cmp("hold_stall", 32'(bus_if.stall), 32'h1F);
      cmp("hold_done",  32'(bus_if.div_done), 32'h0);
    end
    tick(); drive(0, 0, 0, 0, '0);
    cmp("hold_release_done", 32'(bus_if.div_done), 32'h1);
    tick();
    cmp("hold_after_done", 32'(bus_if.div_done), 32'h0);
    cmp("hold_after_busy", 32'(bus_if.div_busy), 32'h0);

    // exception aborts divide
    drive(0, 1, 0, 0, '0);
    tick(); drive(0, 0, 0, 1, 32'h0000_0104);
    tick(); drive(0, 0, 0, 0, '0);
    cmp("exc_flush",  32'(bus_if.flush), 32'h1);
    cmp("exc_rvalid", 32'(bus_if.redirect_valid), 32'h1);
    cmp("exc_rpc",    bus_if.redirect_pc, 32'h20);
    cmp("exc_epc",    bus_if.epc, 32'h104);
    cmp("exc_stall",  32'(bus_if.stall), 32'h0);
    for (int k = 0; k < D + 1; k++) begin
      tick();
      cmp("exc_no_done", 32'(bus_if.div_done), 32'h0);
    end
    cmp("exc_flush_off", 32'(bus_if.flush), 32'h0);

    // all requests together: MEM wins, then divide
    drive(1, 1, 1, 0, '0);
    cmp("all_mem", 32'(bus_if.stall), 32'h1F);
    tick(); drive(1, 0, 0, 0, '0);
    cmp("all_ex", 32'(bus_if.stall), 32'h0F);
    drive(0, 0, 0, 0, '0);
    for (int k = 0; k < D + 2; k++) tick();

    // reset in FLUSH
    drive(0, 0, 0, 1, 32'hDEAD_BEE0);
    tick(); drive(0, 0, 0, 0, '0);
    reset = 1'b1; #1;
    cmp("rstf_stall", 32'(bus_if.stall), 32'h0);
    tick(); reset = 1'b0; #1;
    cmp("rstf_flush", 32'(bus_if.flush), 32'h0);
    cmp("rstf_epc",   bus_if.epc, 32'h0);
    cmp("rstf_rpc",   bus_if.redirect_pc, 32'h0);

    // reset in DIV_BUSY
    drive(0, 1, 0, 0, '0);
    tick(); drive(0, 0, 0, 0, '0);
    reset = 1'b1; #1;
    cmp("rstd_stall", 32'(bus_if.stall), 32'h0);
    cmp("rstd_done",  32'(bus_if.div_done), 32'h0);
    tick(); reset = 1'b0; #1;
    cmp("rstd_busy",  32'(bus_if.div_busy), 32'h0);
    cmp("rstd_stall2", 32'(bus_if.stall), 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom());
    end
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, '0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
